// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU definitions: divider sequencer state encoding and default divider latency.
package CPU_Defines;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } DivState;

    localparam int DIV_LAT_DEFAULT = 32;
    localparam int DIV_CNT_W       = 6;

endpackage

// File: rtl/hazard_stall_unit_div_seq_fsm.sv
// Divider sequencer: tracks an in-flight DIV from start pulse to HI/LO write-back pulse.
module div_seq_fsm
    import CPU_Defines::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic    clk_i,
    input  logic    resetn_i,
    input  logic    flush_i,
    input  logic    start_i,
    output DivState state_o,
    output logic    start_o,
    output logic    busy_o,
    output logic    done_o
);

    // Issue cycle is cycle 0 and BUSY spans cycles 1..DIV_LAT-1, so the counter starts at DIV_LAT-2.
    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_LAT - 2);

    DivState              state_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 start_q;
    logic                 busy_q;
    logic                 done_q;

    // Sequencer state, counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (!resetn_i || flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= BUSY;
                        cnt_q   <= cnt_q - DIV_CNT_W'(1);
                        done_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: load-use interlock plus HI/LO / divider structural interlock.
module hazard_stall_unit
    import CPU_Defines::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       ID_IsHiLoRead,
    input  logic       ID_Issue,
    input  logic       ID_IsLoad,
    input  logic       ID_IsDiv,
    input  logic       ID_Wr,
    input  logic [4:0] ID_Dst,
    input  logic       Flush,
    output logic       ID_Stall,
    output logic       DIV_Start,
    output logic       DIV_Busy,
    output logic       DIV_Done
);

    logic       iss_s;
    logic       load_use_s;
    logic       struct_s;
    logic       div_req_s;
    logic       ld_pend_d;
    logic       ld_pend_q;
    logic [4:0] ld_dst_d;
    logic [4:0] ld_dst_q;
    DivState    div_state_s;

    // Stall decode and next load-tracking state; the stall never depends on issue, so no loop
    always_comb begin
        load_use_s = ld_pend_q && ((ID_UseRs && (ID_rs == ld_dst_q)) ||
                                   (ID_UseRt && (ID_rt == ld_dst_q)));
        struct_s   = (div_state_s != IDLE) && (ID_IsHiLoRead || ID_IsDiv);
        ID_Stall   = (load_use_s || struct_s) && !Flush;
        iss_s      = ID_Issue && !ID_Stall && !Flush;
        div_req_s  = iss_s && ID_IsDiv;
        ld_pend_d  = iss_s && ID_IsLoad && ID_Wr && (ID_Dst != 5'd0);
        if (ld_pend_d) begin
            ld_dst_d = ID_Dst;
        end else begin
            ld_dst_d = ld_dst_q;
        end
    end

    // Pending-load tracking register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ld_pend_q <= 1'b0;
            ld_dst_q  <= 5'd0;
        end else begin
            ld_pend_q <= ld_pend_d;
            ld_dst_q  <= ld_dst_d;
        end
    end

    div_seq_fsm #(
        .DIV_LAT (DIV_LAT)
    ) u_div_seq (
        .clk_i    (clk),
        .resetn_i (resetn),
        .flush_i  (Flush),
        .start_i  (div_req_s),
        .state_o  (div_state_s),
        .start_o  (DIV_Start),
        .busy_o   (DIV_Busy),
        .done_o   (DIV_Done)
    );

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter DIV_LAT, default 32, divider latency in cycles (legal range 2..63).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset is synchronous and active-low.
REQ-004 SHALL have port ID_rs  input  5  source register A of instruction in ID.
REQ-005 SHALL have port ID_rt  input  5  source register B of instruction in ID.
REQ-006 SHALL have port ID_UseRs  input  1  ID instruction reads rs.
REQ-007 SHALL have port ID_UseRt  input  1  ID instruction reads rt.
REQ-008 SHALL have port ID_IsHiLoRead  input  1  ID instruction reads HI/LO.
REQ-009 SHALL have port ID_Issue  input  1  ID instruction valid and requesting advance to EXE.
REQ-010 SHALL have port ID_IsLoad  input  1  ID instruction is a load.
REQ-011 SHALL have port ID_IsDiv  input  1  ID instruction is DIV/DIVU.
REQ-012 SHALL have port ID_Wr  input  1  ID instruction writes a GPR.
REQ-013 SHALL have port ID_Dst  input  5  GPR destination of ID instruction.
REQ-014 SHALL have port Flush  input  1  pipeline flush (exception/eret).
REQ-015 SHALL have port ID_Stall  output  1  hold PC/IF/ID and insert EXE bubble.
REQ-016 SHALL have port DIV_Start  output  1  one-cycle start pulse to divider datapath.
REQ-017 SHALL have port DIV_Busy  output  1  divider occupied.
REQ-018 SHALL have port DIV_Done  output  1  one-cycle pulse; HI/LO written this cycle.

Function
REQ-019 SHALL form effective issue iss = ID_Issue && !ID_Stall && !Flush; only iss updates tracking state.
REQ-020 SHALL register ld_pend/ld_dst: next ld_pend = iss && ID_IsLoad && ID_Wr && ID_Dst!=0, ld_dst = ID_Dst; otherwise ld_pend clears after one cycle.
REQ-021 SHALL assert load-use stall combinationally when ld_pend && ((ID_UseRs && ID_rs==ld_dst) || (ID_UseRt && ID_rt==ld_dst)); register 0 never matches.
REQ-022 SHALL implement FSM states IDLE, BUSY, DONE in the divider sequencer.
REQ-023 SHALL transition IDLE->BUSY on iss && ID_IsDiv, loading counter with DIV_LAT-2; DIV_Start=1 during first BUSY cycle only.
REQ-024 SHALL decrement counter each BUSY cycle; counter==0 in BUSY -> DONE next cycle; no wrap below 0.
REQ-025 SHALL hold DONE exactly one cycle with DIV_Done=1, then IDLE; iss && ID_IsDiv cannot occur in DONE (stalled per REQ-027).
REQ-026 SHALL drive DIV_Busy=1 in BUSY and DONE, 0 in IDLE.
REQ-027 SHALL assert structural stall when state!=IDLE && (ID_IsHiLoRead || ID_IsDiv).
REQ-028 SHALL drive ID_Stall = (load-use stall || structural stall) && !Flush, zero-latency combinational.
REQ-029 SHALL on Flush: next state IDLE, counter 0, ld_pend 0, no DIV_Done pulse; Flush dominates simultaneous issue.
REQ-030 SHALL make total latency div issue -> DIV_Done pulse exactly DIV_LAT cycles (issue cycle = 0).

Reset
REQ-031 SHALL, when resetn=0 at a rising edge, set state IDLE, counter 0, ld_pend 0, ld_dst 0; outputs ID_Stall, DIV_Start, DIV_Busy, DIV_Done all 0 the following cycle.
REQ-032 SHALL let reset override Flush and issue; reset mid-BUSY aborts with no DIV_Done.

Structure
REQ-033 SHALL place DivState enum (IDLE, BUSY, DONE) and default DIV_LAT constant in the shared CPU_Defines package.
REQ-034 SHALL instantiate one sub-module, div_seq_fsm, holding FSM plus counter; load-use logic stays in top.

Verification
REQ-035 SHALL test load-use: lw $5 issued, next ID uses rs=5 -> ID_Stall=1 one cycle, then 0; rs=0 dst=0 -> no stall.
REQ-036 SHALL test div latency with DIV_LAT=32: issue at cycle 0 -> DIV_Start at 1, DIV_Done at 32 only, DIV_Busy 1..32.
REQ-037 SHALL test mfhi during BUSY -> ID_Stall=1 until state IDLE, then released.
REQ-038 SHALL test Flush at cycle 10 of div -> DIV_Busy=0 at 11, DIV_Done never asserted.
REQ-039 SHALL test resetn=0 mid-BUSY with pending load -> all outputs 0 next cycle, subsequent div runs full DIV_LAT.
